// File: rtl/instr_step_ctrl.sv
// Single-step controller: fetches the instruction at Pc from a sync ROM, issues it
// with a Start/Done handshake, then advances Pc (wrap or halt at end of program).
module instr_step_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int LAST_ADDR = 15,
   parameter int WRAP      = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_step,
   input  logic              i_run,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [15:0]       i_rom_data,
   output logic [15:0]       o_instr,
   output logic              o_start,
   input  logic              i_done,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_busy,
   output logic              o_halted,
   output logic              o_err,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_NEXT  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_instr;
   logic              r_pending;
   logic              r_halted;
   logic              r_err;
   logic [7:0]        r_wait_cnt;
   logic              r_refetch;

   state_t            w_state_nxt;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [15:0]       w_instr_nxt;
   logic              w_pending_nxt;
   logic              w_halted_nxt;
   logic              w_err_nxt;
   logic [7:0]        w_wait_cnt_nxt;
   logic              w_refetch_nxt;
   logic              w_at_last;

   assign w_at_last = (r_pc == ADDR_W'(LAST_ADDR));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_instr    <= 16'h0000;
         r_pending  <= 1'b0;
         r_halted   <= 1'b0;
         r_err      <= 1'b0;
         r_wait_cnt <= 8'd0;
         r_refetch  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_pending  <= w_pending_nxt;
         r_halted   <= w_halted_nxt;
         r_err      <= w_err_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_refetch  <= w_refetch_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_pending_nxt  = r_pending;
      w_halted_nxt   = r_halted;
      w_err_nxt      = r_err;
      w_wait_cnt_nxt = r_wait_cnt;
      w_refetch_nxt  = r_refetch;
      case (r_state)
         S_IDLE: begin
            if (i_step || i_run || r_pending) begin
               w_state_nxt   = S_FETCH;
               w_pending_nxt = 1'b0;
               if (i_step) w_err_nxt = 1'b0;
            end
         end
         S_FETCH: begin
            if (i_step) w_pending_nxt = 1'b1;
            // Coming from NEXT the ROM sampled the old Pc, so spend one more cycle here.
            if (r_refetch) begin
               w_refetch_nxt = 1'b0;
            end else begin
               w_instr_nxt = i_rom_data;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (i_step) w_pending_nxt = 1'b1;
            w_wait_cnt_nxt = 8'd0;
            w_state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            if (i_step) w_pending_nxt = 1'b1;
            if (i_done) begin
               w_state_nxt = S_NEXT;
            end else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
         end
         S_NEXT: begin
            if (w_at_last && (WRAP == 0)) begin
               w_halted_nxt = 1'b1;
               w_state_nxt  = S_HALT;
            end else begin
               w_pc_nxt = w_at_last ? '0 : r_pc + ADDR_W'(1);
               if (r_pending || i_run || i_step) begin
                  w_state_nxt   = S_FETCH;
                  w_pending_nxt = 1'b0;
                  w_refetch_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_rom_addr = r_pc;
   assign o_pc       = r_pc;
   assign o_instr    = r_instr;
   assign o_start    = (r_state == S_ISSUE);
   assign o_busy     = (r_state != S_IDLE) && (r_state != S_HALT);
   assign o_halted   = r_halted;
   assign o_err      = r_err;
   assign o_state    = r_state;

endmodule

// File: tb/tb_instr_step_ctrl.sv
// Directed bench for instr_step_ctrl: one wrapping instance (dut_a) and one halting
// instance (dut_b), both LAST_ADDR=3 and TIMEOUT=8, sharing stimulus inputs.
module tb_instr_step_ctrl;

   logic        clk;
   logic        rst;
   logic        step;
   logic        run;
   logic        done;

   logic [3:0]  rom_addr_a, pc_a, rom_addr_b, pc_b;
   logic [15:0] rom_data_a, instr_a, rom_data_b, instr_b;
   logic        start_a, busy_a, halted_a, err_a;
   logic        start_b, busy_b, halted_b, err_b;
   logic [2:0]  state_a, state_b;

   logic [15:0] rom [16];

   int errors;
   int checks;
   int cnt_a;
   int cnt_b;
   logic [3:0]  addr_q_a[$];
   logic [15:0] instr_q_a[$];

   instr_step_ctrl #(.ADDR_W(4), .LAST_ADDR(3), .WRAP(1), .TIMEOUT(8)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_step(step), .i_run(run),
      .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a), .o_instr(instr_a),
      .o_start(start_a), .i_done(done), .o_pc(pc_a), .o_busy(busy_a),
      .o_halted(halted_a), .o_err(err_a), .o_state(state_a)
   );

   instr_step_ctrl #(.ADDR_W(4), .LAST_ADDR(3), .WRAP(0), .TIMEOUT(8)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_step(step), .i_run(run),
      .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b), .o_instr(instr_b),
      .o_start(start_b), .i_done(done), .o_pc(pc_b), .o_busy(busy_b),
      .o_halted(halted_b), .o_err(err_b), .o_state(state_b)
   );

   // clock / reset / ROM
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 16'hA000 + 16'(i);
      rom[0] = 16'h1234;
   end

   always @(posedge clk) begin
      rom_data_a <= rom[rom_addr_a];
      rom_data_b <= rom[rom_addr_b];
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      if (start_a) begin
         cnt_a++;
         addr_q_a.push_back(pc_a);
         instr_q_a.push_back(instr_a);
      end
      if (start_b) cnt_b++;
   endtask

   task automatic clear_mon();
      cnt_a = 0;
      cnt_b = 0;
      addr_q_a.delete();
      instr_q_a.delete();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      step = 1'b0;
      run = 1'b0;
      done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      clear_mon();
   endtask

   task automatic run_one();
      step = 1'b1;
      tick();
      step = 1'b0;
      done = 1'b1;
      repeat (6) tick();
      done = 1'b0;
   endtask

   // tests
   task automatic test_reset();
      rst = 1'b1;
      step = 1'b0;
      run = 1'b0;
      done = 1'b0;
      #12;
      checks++;
      if ({state_a, pc_a, instr_a, start_a, busy_a, halted_a, err_a} !== {3'd0, 4'd0, 16'h0000, 4'b0000}) begin
         errors++;
         $display("FAIL reset_a: state=%0d pc=%0d instr=%h start=%b busy=%b halted=%b err=%b, want all zero",
                  state_a, pc_a, instr_a, start_a, busy_a, halted_a, err_a);
      end
      checks++;
      if (rom_addr_a !== 4'd0) begin
         errors++;
         $display("FAIL reset_rom_addr: got %0d want 0", rom_addr_a);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      clear_mon();
   endtask

   task automatic test_single_step();
      step = 1'b1;                      // cycle t
      checks++;
      if (start_a !== 1'b0) begin errors++; $display("FAIL step_start_t: got %b want 0", start_a); end
      tick(); step = 1'b0;              // t+1
      checks++;
      if (start_a !== 1'b0) begin errors++; $display("FAIL step_start_t1: got %b want 0", start_a); end
      tick();                           // t+2
      checks++;
      if (start_a !== 1'b1 || instr_a !== 16'h1234) begin
         errors++; $display("FAIL step_issue: start=%b instr=%h want 1 1234", start_a, instr_a);
      end
      tick();                           // t+3
      checks++;
      if (start_a !== 1'b0) begin errors++; $display("FAIL step_start_t3: got %b want 0", start_a); end
      tick(); done = 1'b1;              // t+4
      tick(); done = 1'b0;              // t+5
      checks++;
      if (busy_a !== 1'b1 || pc_a !== 4'd0) begin
         errors++; $display("FAIL step_next: busy=%b pc=%0d want 1 0", busy_a, pc_a);
      end
      tick();                           // t+6
      checks++;
      if (pc_a !== 4'd1 || busy_a !== 1'b0 || instr_a !== 16'h1234 || cnt_a != 1) begin
         errors++; $display("FAIL step_done: pc=%0d busy=%b instr=%h starts=%0d want 1 0 1234 1",
                            pc_a, busy_a, instr_a, cnt_a);
      end
   endtask

   task automatic test_pending();
      pulse_reset();
      step = 1'b1;                      // t
      tick(); step = 1'b0;              // t+1
      tick();                           // t+2
      tick(); step = 1'b1;              // t+3 (WAIT)
      tick(); step = 1'b1;              // t+4, dropped
      tick(); step = 1'b0; done = 1'b1; // t+5
      repeat (20) tick();
      done = 1'b0;
      checks++;
      if (cnt_a != 2 || addr_q_a.size() != 2) begin
         errors++; $display("FAIL pending_count: got %0d starts want 2", cnt_a);
      end else begin
         checks++;
         if (addr_q_a[0] !== 4'd0 || addr_q_a[1] !== 4'd1 || instr_q_a[1] !== 16'hA001) begin
            errors++; $display("FAIL pending_addr: got %0d,%0d instr %h want 0,1 a001",
                               addr_q_a[0], addr_q_a[1], instr_q_a[1]);
         end
      end
      checks++;
      if (pc_a !== 4'd2 || busy_a !== 1'b0) begin
         errors++; $display("FAIL pending_pc: pc=%0d busy=%b want 2 0", pc_a, busy_a);
      end
   endtask

   task automatic test_run_wrap();
      logic [3:0] exp_addr [6];
      exp_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
      pulse_reset();
      run = 1'b1;
      done = 1'b1;
      for (int i = 0; i < 100 && addr_q_a.size() < 6; i++) tick();
      run = 1'b0;
      done = 1'b0;
      repeat (10) tick();
      checks++;
      if (addr_q_a.size() < 6) begin
         errors++; $display("FAIL wrap_count: got %0d starts want >=6", addr_q_a.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (addr_q_a[i] !== exp_addr[i] || instr_q_a[i] !== rom[exp_addr[i]]) begin
               errors++; $display("FAIL wrap_seq[%0d]: addr=%0d instr=%h want %0d %h",
                                  i, addr_q_a[i], instr_q_a[i], exp_addr[i], rom[exp_addr[i]]);
            end
         end
      end
      checks++;
      if (halted_a !== 1'b0) begin errors++; $display("FAIL wrap_halted: got %b want 0", halted_a); end
   endtask

   task automatic test_halt();
      pulse_reset();
      run = 1'b1;
      done = 1'b1;
      repeat (60) tick();
      run = 1'b0;
      done = 1'b0;
      checks++;
      if (cnt_b != 4 || pc_b !== 4'd3 || halted_b !== 1'b1 || busy_b !== 1'b0 || state_b !== 3'd5) begin
         errors++; $display("FAIL halt_end: starts=%0d pc=%0d halted=%b busy=%b state=%0d want 4 3 1 0 5",
                            cnt_b, pc_b, halted_b, busy_b, state_b);
      end
      step = 1'b1;
      tick(); step = 1'b0;
      repeat (8) tick();
      run = 1'b1; done = 1'b1;
      repeat (10) tick();
      run = 1'b0; done = 1'b0;
      checks++;
      if (cnt_b != 4 || pc_b !== 4'd3 || halted_b !== 1'b1) begin
         errors++; $display("FAIL halt_sticky: starts=%0d pc=%0d halted=%b want 4 3 1", cnt_b, pc_b, halted_b);
      end
   endtask

   task automatic test_timeout();
      pulse_reset();
      run_one();                        // Pc -> 1
      step = 1'b1;
      tick(); step = 1'b0;
      tick();                           // s: ISSUE
      checks++;
      if (start_a !== 1'b1 || instr_a !== 16'hA001) begin
         errors++; $display("FAIL to_issue: start=%b instr=%h want 1 a001", start_a, instr_a);
      end
      repeat (8) tick();                // s+8
      checks++;
      if (err_a !== 1'b0 || busy_a !== 1'b1) begin
         errors++; $display("FAIL to_early: err=%b busy=%b want 0 1", err_a, busy_a);
      end
      tick();                           // s+9
      checks++;
      if (err_a !== 1'b1 || state_a !== 3'd0 || busy_a !== 1'b0 || pc_a !== 4'd1) begin
         errors++; $display("FAIL to_err: err=%b state=%0d busy=%b pc=%0d want 1 0 0 1",
                            err_a, state_a, busy_a, pc_a);
      end
      step = 1'b1;
      tick(); step = 1'b0;
      checks++;
      if (err_a !== 1'b0) begin errors++; $display("FAIL to_clear: err=%b want 0", err_a); end
      tick();
      checks++;
      if (start_a !== 1'b1 || instr_a !== 16'hA001) begin
         errors++; $display("FAIL to_reissue: start=%b instr=%h want 1 a001", start_a, instr_a);
      end
      done = 1'b1;
      repeat (4) tick();
      done = 1'b0;
      checks++;
      if (pc_a !== 4'd2 || err_a !== 1'b0) begin
         errors++; $display("FAIL to_after: pc=%0d err=%b want 2 0", pc_a, err_a);
      end
   endtask

   task automatic test_reset_mid_wait();
      pulse_reset();
      run_one();
      run_one();                        // Pc -> 2
      step = 1'b1;
      tick(); step = 1'b0;
      tick();                           // ISSUE
      tick();                           // WAIT
      checks++;
      if (pc_a !== 4'd2 || state_a !== 3'd3) begin
         errors++; $display("FAIL rw_setup: pc=%0d state=%0d want 2 3", pc_a, state_a);
      end
      #2 rst = 1'b1;
      #1;
      clear_mon();
      checks++;
      if ({start_a, busy_a, pc_a, instr_a, err_a, halted_a, state_a} !== {2'b00, 4'd0, 16'h0000, 2'b00, 3'd0}) begin
         errors++; $display("FAIL rw_async: start=%b busy=%b pc=%0d instr=%h err=%b halted=%b state=%0d want zeros",
                            start_a, busy_a, pc_a, instr_a, err_a, halted_a, state_a);
      end
      #2 rst = 1'b0;
      tick(); done = 1'b1;
      tick(); done = 1'b0;
      repeat (5) tick();
      checks++;
      if (cnt_a != 0 || pc_a !== 4'd0 || state_a !== 3'd0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL rw_late_done: starts=%0d pc=%0d state=%0d busy=%b want 0 0 0 0",
                            cnt_a, pc_a, state_a, busy_a);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      clear_mon();
      test_reset();
      test_single_step();
      test_pending();
      test_run_wrap();
      test_halt();
      test_timeout();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
